// File: rtl/ahb_wb_pkg.sv
// Shared types and helpers for the AHB-Lite to Wishbone bridge.
package ahb_wb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef logic [2:0] hsize_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR1, ERR2} state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Byte-enable mask for up to 8 lanes; caller slices to its bus width.
    function automatic logic [7:0] calc_sel(input logic [2:0] haddr_lsb, input hsize_t hsize);
        logic [15:0] mask;
        mask = ((16'd1 << (16'd1 << hsize)) - 16'd1) << haddr_lsb;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb_wb_timeout.sv
// Loadable down-counter; expired_o flags the last permitted enabled cycle.
module ahb_wb_timeout #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone B4 master bridge, classic or pipelined, with
// ERROR responses for bus errors, timeouts and misaligned/oversized accesses.
module ahb_wb_bridge
    import ahb_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIPELINED      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic                    wb_stall
);

    localparam int unsigned STRB = DATA_WIDTH / 8;
    localparam int unsigned LSBW = $clog2(STRB);
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ADDR_WIDTH'(STRB - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [STRB-1:0]         sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    accept, bad;
    logic [2:0]              lsb;
    logic [7:0]              sel_full;
    logic                    tmo_load, tmo_en, tmo_expired;
    logic                    unused_ahb;

    assign unused_ahb = ^{HBURST, HPROT, HMASTLOCK};

    always_comb begin
        lsb            = '0;
        lsb[LSBW-1:0]  = HADDR[LSBW-1:0];
        sel_full       = calc_sel(lsb, HSIZE);
        bad            = (HSIZE > 3'(LSBW)) ||
                         ((HADDR[2:0] & ((3'd1 << HSIZE) - 3'd1)) != 3'd0);
        accept         = HSEL && HREADY &&
                         (htrans_t'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ}) &&
                         (state_q inside {IDLE, DONE, ERR2});
    end

    always_comb begin
        state_d  = state_q;
        hrdata_d = hrdata_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        unique case (state_q)
            IDLE, DONE, ERR2: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = bad ? ERR1 : REQ;
                    if (!bad) begin
                        we_d  = HWRITE;
                        sel_d = sel_full[STRB-1:0];
                        adr_d = HADDR & ~ADR_MASK;
                    end
                end
            end
            REQ: begin
                if (wb_err) begin
                    state_d = ERR1;
                end else if (wb_ack) begin
                    state_d  = DONE;
                    hrdata_d = wb_dat_r;
                end else if (tmo_expired) begin
                    state_d = ERR1;
                end else if (PIPELINED != 0 && !wb_stall) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wb_err) begin
                    state_d = ERR1;
                end else if (wb_ack) begin
                    state_d  = DONE;
                    hrdata_d = wb_dat_r;
                end else if (tmo_expired) begin
                    state_d = ERR1;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        // Wishbone controls are registered from the next state.
        cyc_d    = state_d inside {REQ, WAIT};
        stb_d    = (state_d == REQ);
        tmo_load = (state_d == REQ) && (state_q != REQ);
        tmo_en   = state_q inside {REQ, WAIT};
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q  <= IDLE;
            hrdata_q <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
        end else begin
            state_q  <= state_d;
            hrdata_q <= hrdata_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_tmo
            ahb_wb_timeout #(
                .WIDTH (TW)
            ) u_timeout (
                .clk_i      (clk_core),
                .rst_i      (rst_core),
                .load_i     (tmo_load),
                .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
                .en_i       (tmo_en),
                .expired_o  (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    assign HREADYOUT = !(state_q inside {REQ, WAIT, ERR1});
    assign HRESP     = (state_q inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = hrdata_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = stb_q;
    assign wb_we     = we_q;
    assign wb_sel    = sel_q;
    assign wb_adr    = adr_q;
    // AHB keeps HWDATA stable while the beat is stretched, so it is passed live.
    assign wb_dat_w  = (cyc_q && we_q) ? HWDATA : '0;

endmodule
